xor_stream_deframer: RTL and testbench
======================================

// Module: xor_stream_deframer
// PURPOSE
//   Downstream stage of the dual XOR stream cipher receive path. Consumes the
//   decrypted serial bitstream (rx_p, qualified by rx_en) and hunts for a sync
//   byte. After sync it assembles a fixed-length payload into bytes and presents
//   them on a valid/ready byte interface, with lock, frame-done and overrun status.
// PARAMETERS
//   SYNC         8'hA5  sync byte, received MSB-first, that marks frame start
//   PAYLOAD_LEN  4      payload bytes per frame, 1..255
// PORTS
//   clk         in   1  clock
//   rst         in   1  asynchronous, active-low reset
//   bit_i       in   1  decrypted serial bit (cipher rx_p)
//   bit_en      in   1  bit qualifier; bit_i sampled only when high
//   byte_o      out  8  assembled payload byte
//   byte_valid  out  1  byte_o holds an unconsumed byte
//   byte_ready  in   1  consumer accepts byte_o when byte_valid & byte_ready
//   locked      out  1  high while inside a frame (after sync, until frame end)
//   frame_done  out  1  one-cycle pulse at frame end
//   overrun     out  1  sticky: payload byte lost because holding reg was full
//   chk_err     out  1  one-cycle pulse, checksum mismatch (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst=0, async): state=HUNT, shreg=0, bit/byte counters=0, byte_o=0,
//   byte_valid=0, locked=0, frame_done=0, overrun=0, chk_err=0, chk_acc=0.
//   Reset mid-frame discards the partial frame and the held byte.
// - All state advances only on cycles with bit_en=1; bit_en=0 holds all state
//   (byte handshake and frame_done/chk_err pulse clearing still operate).
// - Shift MSB-first: shreg_next = {shreg[6:0], bit_i}.
// - FSM states: HUNT, PAYLOAD, CHECK (CHECK exists only with CHECKSUM_EN).
// - HUNT: shift every bit. When shreg_next==SYNC, go to PAYLOAD; clear bit
//   count, byte count and chk_acc; locked=1 from the next cycle.
//   Sliding match: sync can start at any bit position.
// - PAYLOAD: shift; bit count 0..7. On the 8th bit, the byte is complete:
//     - If holding reg is free, or is being consumed this same cycle, then
//       byte_o<=shreg_next, byte_valid<=1.
//     - Otherwise the byte is dropped and overrun<=1 (sticky until reset).
//     - chk_acc ^= shreg_next; byte count increments.
//   When the byte count reaches PAYLOAD_LEN, go to CHECK if CHECKSUM_EN is
//   defined, else end the frame.
// - Latency: byte_valid rises the cycle after the edge that samples the 8th bit.
// - Handshake: byte_valid & byte_ready clears byte_valid next cycle, unless a
//   new byte loads that same edge (valid stays 1, byte_o updates). byte_o is
//   stable while byte_valid=1 and not accepted. byte_ready ignored when
//   byte_valid=0.
// - Frame end: frame_done=1 for exactly one cycle; locked<=0; state<=HUNT;
//   shreg<=0, so a new sync needs 8 fresh bits (no overlap with tail bits).
// - The held byte survives frame end and the return to HUNT until consumed.
// - Count widths: bit count 3 bits (wraps 7->0); byte count 8 bits.
// CONFIGURATION
// - Macro CHECKSUM_EN defined: after the payload, CHECK shifts 8 more bits
//   (the checksum byte, never presented on byte_o).
//     - On its 8th bit: frame ends and, if shreg_next != chk_acc, chk_err
//       pulses the same cycle as frame_done.
//     - locked stays 1 through CHECK.
// - CHECKSUM_EN undefined: no CHECK state and no chk_acc. chk_err is tied to
//   0. The frame ends on the last payload bit.
// TESTING
// 1. Reset, then send 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44 with bit_en=1 and
//    byte_ready=1 -> bytes 11,22,33,44 in order; locked high from sync to end;
//    one frame_done pulse.
// 2. Noise 3'b101 then A5 (sliding match) -> lock after the 11th bit; payload
//    bytes correct.
// 3. byte_ready=0 for the whole frame -> byte_o=8'h11 held valid; overrun=1
//    after the 2nd byte completes; bytes 22-44 lost.
// 4. bit_en toggled 1/0 each cycle with frame of test 1 -> identical byte
//    sequence; no extra state changes on bit_en=0 cycles.
// 5. Assert rst after 4 payload bits of byte 8'h22 -> all outputs 0 async;
//    a fresh A5 frame afterwards is received correctly.
// 6. CHECKSUM_EN: payload 11,22,33,44 with checksum 8'h44 -> chk_err=0;
//    checksum 8'h45 -> chk_err pulse coincident with frame_done.

Source files
------------

// File: rtl/xor_stream_deframer_if.sv
// Byte-stream side of the deframer: serial bit input, valid/ready byte output and status.
// The slave modport is the deframer; the master modport is whoever feeds and drains it.
interface xor_stream_deframer_if;
    logic       bit_i;
    logic       bit_en;
    logic [7:0] byte_o;
    logic       byte_valid;
    logic       byte_ready;
    logic       locked;
    logic       frame_done;
    logic       overrun;
    logic       chk_err;

    modport master (
        output bit_i, bit_en, byte_ready,
        input  byte_o, byte_valid, locked, frame_done, overrun, chk_err
    );

    modport slave (
        input  bit_i, bit_en, byte_ready,
        output byte_o, byte_valid, locked, frame_done, overrun, chk_err
    );
endinterface

// File: rtl/xor_stream_deframer.sv
// Sync-byte hunter and fixed-length payload assembler for the XOR stream cipher receive path.
// Define CHECKSUM_EN to expect a trailing XOR checksum byte after each payload.
module xor_stream_deframer #(
    parameter logic [7:0] SYNC        = 8'hA5,
    parameter int         PAYLOAD_LEN = 4
) (
    input logic                  clk,
    input logic                  rst,
    xor_stream_deframer_if.slave dif
);

    localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_LEN - 1);

`ifdef CHECKSUM_EN
    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;
`else
    typedef enum logic [1:0] {HUNT, PAYLOAD} state_t;
`endif

    state_t     state_q;
    logic [7:0] shreg_q;
    logic [7:0] shreg_d;
    logic [2:0] bit_cnt_q;
    logic [7:0] byte_cnt_q;
    logic [7:0] byte_o_q;
    logic       byte_valid_q;
    logic       locked_q;
    logic       frame_done_q;
    logic       overrun_q;
    logic       byte_accept;
`ifdef CHECKSUM_EN
    logic [7:0] chk_acc_q;
    logic       chk_err_q;
`endif

    assign shreg_d     = {shreg_q[6:0], dif.bit_i};
    assign byte_accept = byte_valid_q & dif.byte_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= HUNT;
            shreg_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 8'd0;
            byte_o_q     <= 8'h00;
            byte_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef CHECKSUM_EN
            chk_acc_q    <= 8'h00;
            chk_err_q    <= 1'b0;
`endif
        end else begin
            frame_done_q <= 1'b0;
`ifdef CHECKSUM_EN
            chk_err_q    <= 1'b0;
`endif
            if (byte_accept) begin
                byte_valid_q <= 1'b0;
            end
            if (dif.bit_en) begin
                shreg_q <= shreg_d;
                case (state_q)
                    HUNT: begin
                        if (shreg_d == SYNC) begin
                            state_q    <= PAYLOAD;
                            bit_cnt_q  <= 3'd0;
                            byte_cnt_q <= 8'd0;
                            locked_q   <= 1'b1;
`ifdef CHECKSUM_EN
                            chk_acc_q  <= 8'h00;
`endif
                        end
                    end
                    PAYLOAD: begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            // A byte being accepted this edge frees the holding register.
                            if (!byte_valid_q || byte_accept) begin
                                byte_o_q     <= shreg_d;
                                byte_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                            byte_cnt_q <= byte_cnt_q + 8'd1;
`ifdef CHECKSUM_EN
                            chk_acc_q <= chk_acc_q ^ shreg_d;
                            if (byte_cnt_q == LAST_BYTE) begin
                                state_q <= CHECK;
                            end
`else
                            if (byte_cnt_q == LAST_BYTE) begin
                                state_q      <= HUNT;
                                locked_q     <= 1'b0;
                                frame_done_q <= 1'b1;
                                shreg_q      <= 8'h00;
                            end
`endif
                        end
                    end
`ifdef CHECKSUM_EN
                    CHECK: begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q      <= HUNT;
                            locked_q     <= 1'b0;
                            frame_done_q <= 1'b1;
                            shreg_q      <= 8'h00;
                            chk_err_q    <= (shreg_d != chk_acc_q);
                        end
                    end
`endif
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign dif.byte_o     = byte_o_q;
    assign dif.byte_valid = byte_valid_q;
    assign dif.locked     = locked_q;
    assign dif.frame_done = frame_done_q;
    assign dif.overrun    = overrun_q;
`ifdef CHECKSUM_EN
    assign dif.chk_err    = chk_err_q;
`else
    assign dif.chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_xor_stream_deframer.sv
// Self-checking bench for xor_stream_deframer: directed frames plus randomized noise/bit_en,
// checked against a stream-level parser model of the framing rules.
module tb_xor_stream_deframer;

    localparam int         PLEN = 4;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef CHECKSUM_EN
    localparam int CHK_BITS = 8;
`else
    localparam int CHK_BITS = 0;
`endif
    localparam int FRAME_BITS = PLEN * 8 + CHK_BITS;

    logic clk = 1'b0;
    logic rst = 1'b0;

    xor_stream_deframer_if dif();

    xor_stream_deframer #(
        .SYNC        (SYNC),
        .PAYLOAD_LEN (PLEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    bit         stim[$];
    bit         m_lk[$];
    bit         m_dn[$];
    bit         m_ce[$];
    bit         m_cmp[$];
    int         m_nb[$];
    logic [7:0] m_bytes[$];
    logic [7:0] got[$];

    // Bytes actually handed over: valid & ready just before the edge.
    always @(negedge clk) begin
        if (rst && dif.byte_valid === 1'b1 && dif.byte_ready === 1'b1)
            got.push_back(dif.byte_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) stim.push_back(b[i]);
    endtask

    task automatic push_frame(input logic [31:0] pl);
        logic [7:0] x;
        x = pl[31:24] ^ pl[23:16] ^ pl[15:8] ^ pl[7:0];
        push_byte(SYNC);
        push_byte(pl[31:24]);
        push_byte(pl[23:16]);
        push_byte(pl[15:8]);
        push_byte(pl[7:0]);
        if (CHK_BITS != 0) push_byte(x);
    endtask

    // Parse the enabled-bit stream: sliding sync search, then fixed-length frame body.
    task automatic model();
        logic [7:0] win, cur, acc;
        bit         inf, d, e, c;
        int         fb, n;
        win = 8'h00; cur = 8'h00; acc = 8'h00; inf = 1'b0; fb = 0; n = 0;
        m_lk.delete(); m_dn.delete(); m_ce.delete(); m_cmp.delete(); m_nb.delete(); m_bytes.delete();
        foreach (stim[i]) begin
            d = 1'b0; e = 1'b0; c = 1'b0;
            if (!inf) begin
                win = {win[6:0], stim[i]};
                if (win == SYNC) begin
                    inf = 1'b1; fb = 0; acc = 8'h00;
                end
            end else begin
                cur = {cur[6:0], stim[i]};
                fb++;
                if (fb % 8 == 0) begin
                    if (fb <= PLEN * 8) begin
                        m_bytes.push_back(cur);
                        acc ^= cur;
                        n++;
                        c = 1'b1;
                    end else if (cur != acc) begin
                        e = 1'b1;
                    end
                    if (fb == FRAME_BITS) begin
                        inf = 1'b0; win = 8'h00; d = 1'b1;
                    end
                end
            end
            m_lk.push_back(inf);
            m_dn.push_back(d);
            m_ce.push_back(e);
            m_cmp.push_back(c);
            m_nb.push_back(n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        dif.bit_i = 1'b0; dif.bit_en = 1'b0; dif.byte_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        stim.delete();
    endtask

    // en_mode: 0 = always enabled, 1 = alternate 1/0, 2 = random.
    task automatic run(input string name, input int en_mode, input bit rdy, input bit chk_bytes);
        int k;
        bit tog, prev_lk, en;
        k = 0; tog = 1'b0; prev_lk = 1'b0;
        model();
        got.delete();
        while (k < stim.size()) begin
            case (en_mode)
                0:       en = 1'b1;
                1:       begin tog = ~tog; en = tog; end
                default: en = bit'($urandom_range(0, 1));
            endcase
            dif.bit_en     = en;
            dif.bit_i      = en ? stim[k] : bit'($urandom_range(0, 1));
            dif.byte_ready = rdy;
            @(posedge clk); #1;
            if (en) begin
                check({name, "/locked"},     dif.locked,     m_lk[k]);
                check({name, "/frame_done"}, dif.frame_done, m_dn[k]);
                check({name, "/chk_err"},    dif.chk_err,    m_ce[k]);
                if (rdy) begin
                    check({name, "/byte_valid"}, dif.byte_valid, m_cmp[k]);
                    check({name, "/overrun"},    dif.overrun,    1'b0);
                end else begin
                    check({name, "/byte_valid"}, dif.byte_valid, m_nb[k] >= 1);
                    check({name, "/overrun"},    dif.overrun,    m_nb[k] >= 2);
                end
                if (m_cmp[k] && (rdy || m_nb[k] == 1))
                    check({name, "/byte_o"}, dif.byte_o, m_bytes[m_nb[k] - 1]);
                prev_lk = m_lk[k];
                k++;
            end else begin
                check({name, "/locked_hold"}, dif.locked,     prev_lk);
                check({name, "/done_idle"},   dif.frame_done, 1'b0);
                check({name, "/chk_idle"},    dif.chk_err,    1'b0);
            end
        end
        dif.bit_en = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        if (chk_bytes) begin
            check({name, "/nbytes"}, got.size(), m_bytes.size());
            foreach (m_bytes[i]) begin
                if (i < got.size()) begin
                    $display("%s byte %0d: got %02h exp %02h", name, i, got[i], m_bytes[i]);
                    check({name, "/rx_byte"}, got[i], m_bytes[i]);
                end
            end
        end
        $display("%s: %0d bits, %0d bytes expected, %0d handed over", name, stim.size(), m_bytes.size(), got.size());
    endtask

    initial begin
        dif.bit_i = 1'b0; dif.bit_en = 1'b0; dif.byte_ready = 1'b0;
        #2;
        check("reset/byte_o",     dif.byte_o,     8'h00);
        check("reset/byte_valid", dif.byte_valid, 1'b0);
        check("reset/locked",     dif.locked,     1'b0);
        check("reset/frame_done", dif.frame_done, 1'b0);
        check("reset/overrun",    dif.overrun,    1'b0);
        check("reset/chk_err",    dif.chk_err,    1'b0);

        // 1: basic frame
        do_reset();
        push_frame(32'h11223344);
        run("t1_basic", 0, 1'b1, 1'b1);

        // 2: sliding sync after noise 101
        do_reset();
        stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1);
        push_frame(32'h11223344);
        run("t2_slide", 0, 1'b1, 1'b1);

        // 3: consumer never ready -> first byte held, later bytes lost
        do_reset();
        push_frame(32'h11223344);
        run("t3_stall", 0, 1'b0, 1'b0);
        check("t3/held_byte",  dif.byte_o,     8'h11);
        check("t3/held_valid", dif.byte_valid, 1'b1);
        check("t3/overrun",    dif.overrun,    1'b1);
        dif.byte_ready = 1'b1;
        @(posedge clk); #1;
        check("t3/drained",    dif.byte_valid, 1'b0);
        check("t3/sticky",     dif.overrun,    1'b1);

        // 4: bit_en alternating
        do_reset();
        push_frame(32'h11223344);
        run("t4_toggle", 1, 1'b1, 1'b1);

        // 5: async reset mid-byte, then a clean frame
        do_reset();
        push_byte(SYNC);
        push_byte(8'h11);
        stim.push_back(1'b0); stim.push_back(1'b0); stim.push_back(1'b1); stim.push_back(1'b0);
        run("t5_partial", 0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("t5/byte_o",     dif.byte_o,     8'h00);
        check("t5/byte_valid", dif.byte_valid, 1'b0);
        check("t5/locked",     dif.locked,     1'b0);
        check("t5/frame_done", dif.frame_done, 1'b0);
        check("t5/overrun",    dif.overrun,    1'b0);
        check("t5/chk_err",    dif.chk_err,    1'b0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        stim.delete();
        push_frame(32'h11223344);
        run("t5_fresh", 0, 1'b1, 1'b1);

`ifdef CHECKSUM_EN
        // 6: explicit good and bad checksum bytes
        do_reset();
        push_byte(SYNC); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        push_byte(8'h44);
        run("t6_good", 0, 1'b1, 1'b1);
        do_reset();
        push_byte(SYNC); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        push_byte(8'h45);
        run("t6_bad", 0, 1'b1, 1'b1);
`endif

        // Randomized: random noise, random payloads, random bit_en
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int f = 0; f < 2; f++) begin
                int nl;
                nl = int'($urandom_range(0, 12));
                for (int i = 0; i < nl; i++) stim.push_back(bit'($urandom_range(0, 1)));
                push_frame($urandom);
            end
            run("rand", 2, 1'b1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
